icache_refill: RTL and testbench
================================

# icache_refill

Miss-handling and refill controller on the instruction-fetch side of the direct-mapped instruction cache. It takes fetch requests from the IF stage and looks them up through the cache's combinational read port. On a miss it fetches the 32-bit instruction byte-by-byte through the memory controller's byte port, assembles it little-endian, writes it into the cache, and returns it to IF. It is the writer of the cache fill port and the consumer of the cache hit port.

## Interface
- No parameters. Widths come from the shared defines: `InstAddrBus` is 31:0 and `InstBus` is 31:0.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; when low, all state and outputs freeze
- req_i  in  1  IF fetch request; level, held until valid_o
- pc_i  in  32  fetch PC; pc_i[1:0] is always 0
- flush_i  in  1  branch/jump redirect; aborts the current request
- valid_o  out  1  single-cycle pulse: inst_o is valid for pc_i
- inst_o  out  32  fetched instruction
- rpc_o  out  32  cache read PC (equals pc_i)
- hit_i  in  1  cache hit
- cinst_i  in  32  cache read data
- we_o  out  1  cache fill write enable; single-cycle pulse
- wpc_o  out  32  fill PC
- winst_o  out  32  fill instruction
- mem_req_o  out  1  byte-read request
- mem_addr_o  out  32  byte address
- mem_gnt_i  in  1  arbiter grant; a request issues in a cycle where mem_req_o and mem_gnt_i are both high
- mem_data_i  in  8  read byte; valid exactly 1 cycle after its issue cycle

## Operation
- States:
  - IDLE: lookup.
  - FETCH: issue and collect bytes.
  - FILL: write the cache and respond.
- IDLE, req_i && hit_i && !flush_i:
  - valid_o=1 and inst_o=cinst_i in the same cycle.
  - Stay in IDLE.
- IDLE, req_i && !hit_i && !flush_i:
  - Latch base = pc_i.
  - Clear issue_cnt and recv_cnt (3 bits each, range 0..4).
  - Go to FETCH.
- FETCH, issuing:
  - mem_req_o = (issue_cnt < 4).
  - mem_addr_o = base + issue_cnt, a 32-bit add with no wrap handling needed.
  - issue_cnt increments on each issue.
- FETCH, collecting:
  - The byte arriving for issue k is written to buf[8k+7:8k].
  - recv_cnt increments on each arriving byte.
  - A pending flag per cycle tracks whether the previous cycle issued a request.
- FETCH exit:
  - recv_cnt reaches 4 → FILL.
  - With REFILL_FORWARD_EN, see Configuration.
- FILL:
  - we_o=1, wpc_o=base, winst_o=buf.
  - valid_o=1, inst_o=buf.
  - Go to IDLE.
- flush_i in any state:
  - Takes priority over everything else.
  - Go to IDLE with no we_o and no valid_o.
  - mem_req_o=0 in that cycle.
  - A byte that arrives after a flush is ignored.
- Any new miss accepted after a flush starts clean at issue_cnt=0.
- req_i low in IDLE: no activity, all pulses 0.
- rdy low: no state, counter or buffer change. valid_o, we_o and mem_req_o are forced to 0. A byte returning during rdy low is captured. The memory controller freezes under the same rdy, so no further bytes arrive.
- Reset values:
  - State = IDLE.
  - Counters 0, buf 0, base 0.
  - valid_o, we_o, mem_req_o = 0.
  - inst_o, winst_o, wpc_o, mem_addr_o = 0.
- rst mid-refill: immediately IDLE; no fill is written.

## Timing
- Hit: 0-cycle latency; valid_o in the request cycle.
- Miss with mem_gnt_i held high, miss accepted in cycle 0:
  - Issues in cycles 1–4.
  - Bytes arrive in cycles 2–5.
  - FILL (we_o, valid_o) in cycle 6.
  - Next request is looked up in cycle 7.
- Each cycle with mem_gnt_i low delays all later events by 1 cycle.
- we_o and valid_o are asserted in the same cycle. A same-address lookup in the next cycle hits.

## Configuration
- Macro: REFILL_FORWARD_EN.
- Defined:
  - In the cycle the 4th byte arrives, valid_o, inst_o, we_o and winst_o are driven directly from {mem_data_i, buf[23:0]}.
  - FILL is skipped; the next state is IDLE.
  - Miss latency drops by 1 (cycle 5 in the example above).
- Undefined: behaviour is as in Operation, using the registered FILL state.

## Structure
- Shared defines: `InstAddrBus`, `InstBus`, `ZeroWord`, the state encodings (IDLE/FETCH/FILL), and the byte count constant `InstBytes`=4.
- One sub-module, `inst_byte_assembler`:
  - Holds buf and recv_cnt.
  - Inputs: byte, valid, clear.
  - Outputs: word, done.
- Control FSM, issue counter and address generation stay in `icache_refill`.

## Test plan
- Hit: hit_i=1, cinst_i=0x00A00513, req_i at pc 0x1000 → valid_o=1 with inst 0x00A00513 the same cycle; mem_req_o stays 0.
- Miss with full grant: pc 0x1004, memory bytes 13,05,A0,00 → addresses 0x1004–0x1007 issued in cycles 1–4; we_o and valid_o in cycle 6 with 0x00A00513; wpc_o=0x1004.
- Grant gaps: mem_gnt_i low in cycles 2 and 3 → fill is 2 cycles later, and no address is skipped or repeated.
- Flush after 2 bytes issued → no we_o and no valid_o; a following miss at 0x2000 issues from 0x2000; the stale byte does not corrupt the new word.
- rst asserted in FETCH, and rdy low for 3 cycles in FETCH → rst: all outputs 0 next cycle; rdy: no pulses while low, and the refill resumes correctly.
- With REFILL_FORWARD_EN: the full-grant miss case completes in cycle 5 with the same value.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared widths, state encodings and constants for the instruction-cache refill controller.
// The optional REFILL_FORWARD_EN feature is selected in icache_refill.sv.
package icache_refill_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] FILL  = 2'd2;

   localparam logic [2:0] INST_BYTES = 3'd4;

endpackage

// File: rtl/icache_refill_byte_asm.sv
// inst_byte_assembler: collects four in-order bytes into a little-endian instruction word.
// word and done already include a byte arriving this cycle so the parent can forward it.
import icache_refill_pkg::*;

module inst_byte_assembler (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          data,
   input  logic                valid,
   input  logic                clear,
   output logic [INST_W-1:0]   word,
   output logic                done
);

   logic [INST_W-1:0] word_buf;
   logic [2:0]        recv_cnt;
   logic              take;
   logic [INST_W-1:0] merged;

   assign take = valid && (recv_cnt < INST_BYTES);

   // Bytes arrive in issue order, so the receive count selects the byte lane.
   always_comb begin
      merged = word_buf;
      if (take) begin
         merged[{recv_cnt[1:0], 3'b000} +: 8] = data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word_buf <= ZERO_WORD;
         recv_cnt <= 3'd0;
      end else if (take) begin
         word_buf <= merged;
         recv_cnt <= recv_cnt + 3'd1;
      end
   end

   assign word = merged;
   assign done = (recv_cnt == INST_BYTES) || (take && (recv_cnt == INST_BYTES - 3'd1));

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: hit pass-through, byte-wise refill over the memory port, cache fill.
// Define REFILL_FORWARD_EN to respond in the cycle the last byte arrives instead of a registered FILL.
import icache_refill_pkg::*;

module icache_refill (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     req_i,
   input  logic [INST_ADDR_W-1:0]   pc_i,
   input  logic                     flush_i,
   output logic                     valid_o,
   output logic [INST_W-1:0]        inst_o,
   output logic [INST_ADDR_W-1:0]   rpc_o,
   input  logic                     hit_i,
   input  logic [INST_W-1:0]        cinst_i,
   output logic                     we_o,
   output logic [INST_ADDR_W-1:0]   wpc_o,
   output logic [INST_W-1:0]        winst_o,
   output logic                     mem_req_o,
   output logic [INST_ADDR_W-1:0]   mem_addr_o,
   input  logic                     mem_gnt_i,
   input  logic [7:0]               mem_data_i
);

   logic [1:0]             state;
   logic [1:0]             next_state;
   logic [INST_ADDR_W-1:0] base;
   logic [2:0]             issue_cnt;
   logic                   pending;
   logic                   live;
   logic                   in_fetch;
   logic                   hit_resp;
   logic                   miss_acc;
   logic                   issue;
   logic                   byte_valid;
   logic                   fill_resp;
   logic [INST_W-1:0]      asm_word;
   logic                   asm_done;

   assign live       = rdy && !rst && !flush_i;
   assign in_fetch   = (state == FETCH);
   assign hit_resp   = live && (state == IDLE) && req_i && hit_i;
   assign miss_acc   = live && (state == IDLE) && req_i && !hit_i;
   assign mem_req_o  = live && in_fetch && (issue_cnt < INST_BYTES);
   assign issue      = mem_req_o && mem_gnt_i;
   // A returning byte is kept even while rdy is low; a flush discards it.
   assign byte_valid = pending && in_fetch && !flush_i;

`ifdef REFILL_FORWARD_EN
   assign fill_resp = live && in_fetch && asm_done;
`else
   assign fill_resp = live && (state == FILL);
`endif

   inst_byte_assembler u_asm (
      .clk   (clk),
      .rst   (rst),
      .data  (mem_data_i),
      .valid (byte_valid),
      .clear (miss_acc),
      .word  (asm_word),
      .done  (asm_done)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (miss_acc) next_state = FETCH;
`ifdef REFILL_FORWARD_EN
         FETCH:   if (asm_done) next_state = IDLE;
`else
         FETCH:   if (asm_done) next_state = FILL;
`endif
         FILL:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush_i) next_state = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base      <= ZERO_WORD;
         issue_cnt <= 3'd0;
         pending   <= 1'b0;
      end else begin
         pending <= issue;
         if (rdy) state <= next_state;
         if (miss_acc) begin
            base      <= pc_i;
            issue_cnt <= 3'd0;
         end else if (issue) begin
            issue_cnt <= issue_cnt + 3'd1;
         end
      end
   end

   assign rpc_o      = pc_i;
   assign valid_o    = hit_resp || fill_resp;
   assign we_o       = fill_resp;
   assign inst_o     = hit_resp ? cinst_i : (fill_resp ? asm_word : ZERO_WORD);
   assign wpc_o      = fill_resp ? base : ZERO_WORD;
   assign winst_o    = fill_resp ? asm_word : ZERO_WORD;
   assign mem_addr_o = mem_req_o ? (base + {29'd0, issue_cnt}) : ZERO_WORD;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: table-driven hit/miss vectors plus multi-cycle corner cases.
// Expectations follow REFILL_FORWARD_EN when the macro is defined for the build.
module tb_icache_refill;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        req_i = 1'b0;
   logic [31:0] pc_i = 32'h0;
   logic        flush_i = 1'b0;
   logic        valid_o;
   logic [31:0] inst_o;
   logic [31:0] rpc_o;
   logic        hit_i = 1'b0;
   logic [31:0] cinst_i = 32'h0;
   logic        we_o;
   logic [31:0] wpc_o;
   logic [31:0] winst_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 1'b1;
   logic [7:0]  mem_data_i = 8'hEE;

   int checks = 0;
   int fails = 0;

   logic        issued_last = 1'b0;
   logic [31:0] addr_last = 32'h0;

`ifdef REFILL_FORWARD_EN
   localparam int FILL_LAT = 5;
`else
   localparam int FILL_LAT = 6;
`endif

   typedef struct {
      logic        req;
      logic [31:0] pc;
      logic        hit;
      logic [31:0] cinst;
      logic        gnt;
      logic        flush;
      logic        exp_valid;
      logic [31:0] exp_inst;
      logic        exp_we;
      logic [31:0] exp_wpc;
      logic [31:0] exp_winst;
      logic        exp_mreq;
      logic [31:0] exp_maddr;
   } vec_t;

   vec_t vecs[$];

   icache_refill dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .req_i      (req_i),
      .pc_i       (pc_i),
      .flush_i    (flush_i),
      .valid_o    (valid_o),
      .inst_o     (inst_o),
      .rpc_o      (rpc_o),
      .hit_i      (hit_i),
      .cinst_i    (cinst_i),
      .we_o       (we_o),
      .wpc_o      (wpc_o),
      .winst_o    (winst_o),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_gnt_i  (mem_gnt_i),
      .mem_data_i (mem_data_i)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h1004: return 8'h13;
         32'h1005: return 8'h05;
         32'h1006: return 8'hA0;
         32'h1007: return 8'h00;
         32'h2000: return 8'h78;
         32'h2001: return 8'h56;
         32'h2002: return 8'h34;
         32'h2003: return 8'h12;
         default:  return a[7:0] + 8'h11;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One clock: drive after the edge, return the byte issued last cycle, then let outputs settle.
   task automatic apply_stimulus(input logic req, input logic [31:0] pc, input logic hit,
                                 input logic [31:0] cinst, input logic gnt, input logic flush,
                                 input logic rdy_v, input logic rst_v);
      @(posedge clk);
      #1;
      mem_data_i = issued_last ? mem_byte(addr_last) : 8'hEE;
      req_i   = req;
      pc_i    = pc;
      hit_i   = hit;
      cinst_i = cinst;
      mem_gnt_i = gnt;
      flush_i = flush;
      rdy     = rdy_v;
      rst     = rst_v;
      #3;
      issued_last = mem_req_o && mem_gnt_i;
      addr_last   = mem_addr_o;
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_valid"}, {31'd0, valid_o}, 32'd0);
      check({name, "_we"}, {31'd0, we_o}, 32'd0);
      check({name, "_mreq"}, {31'd0, mem_req_o}, 32'd0);
      check({name, "_inst"}, inst_o, 32'd0);
      check({name, "_wpc"}, wpc_o, 32'd0);
      check({name, "_winst"}, winst_o, 32'd0);
      check({name, "_maddr"}, mem_addr_o, 32'd0);
   endtask

   // Drives one miss to completion with per-cycle grant/rdy patterns (bit c = cycle c).
   task automatic run_miss(input string name, input logic [31:0] pc, input logic [31:0] gnt_pat,
                           input logic [31:0] rdy_pat, input int exp_lat, input logic [31:0] exp_word);
      int n_issued = 0;
      int fill_cyc = -1;
      logic addr_bad = 1'b0;
      logic pulse_bad = 1'b0;
      logic [31:0] got_inst = 32'h0;
      logic [31:0] got_wpc = 32'h0;
      logic [31:0] got_winst = 32'h0;
      logic got_we = 1'b0;
      for (int c = 0; c < 32 && fill_cyc < 0; c++) begin
         apply_stimulus(1'b1, pc, 1'b0, 32'hBAD0BAD0, gnt_pat[c], 1'b0, rdy_pat[c], 1'b0);
         if (!rdy_pat[c] && (valid_o || we_o || mem_req_o)) pulse_bad = 1'b1;
         if (mem_req_o && mem_gnt_i) begin
            if (mem_addr_o !== pc + 32'(n_issued)) addr_bad = 1'b1;
            n_issued++;
         end
         if (valid_o) begin
            fill_cyc  = c;
            got_inst  = inst_o;
            got_we    = we_o;
            got_wpc   = wpc_o;
            got_winst = winst_o;
         end
      end
      check({name, "_latency"}, 32'(fill_cyc), 32'(exp_lat));
      check({name, "_issues"}, 32'(n_issued), 32'd4);
      check({name, "_addr_seq"}, {31'd0, addr_bad}, 32'd0);
      check({name, "_rdy_pulse"}, {31'd0, pulse_bad}, 32'd0);
      check({name, "_inst"}, got_inst, exp_word);
      check({name, "_we"}, {31'd0, got_we}, 32'd1);
      check({name, "_wpc"}, got_wpc, pc);
      check({name, "_winst"}, got_winst, exp_word);
   endtask

   initial begin
      int pulses;

      // Hits, idle, and a full-grant miss at 0x1004 followed by a same-address hit.
      vecs.push_back('{1'b0, 32'h0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h1000, 1'b1, 32'h00A00513, 1'b1, 1'b0, 1'b1, 32'h00A00513, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h1008, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1004});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1005});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1006});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1007});
`ifdef REFILL_FORWARD_EN
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00A00513, 1'b1, 32'h1004, 32'h00A00513, 1'b0, 32'h0});
`else
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00A00513, 1'b1, 32'h1004, 32'h00A00513, 1'b0, 32'h0});
`endif
      vecs.push_back('{1'b1, 32'h1004, 1'b1, 32'h00A00513, 1'b1, 1'b0, 1'b1, 32'h00A00513, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});

      $display("[TB] reset");
      apply_stimulus(1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 32'h1004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_idle_outputs("reset");

      $display("[TB] vector table");
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].req, vecs[i].pc, vecs[i].hit, vecs[i].cinst, vecs[i].gnt,
                        vecs[i].flush, 1'b1, 1'b0);
         check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_inst", i), inst_o, vecs[i].exp_inst);
         check($sformatf("vec%0d_we", i), {31'd0, we_o}, {31'd0, vecs[i].exp_we});
         check($sformatf("vec%0d_wpc", i), wpc_o, vecs[i].exp_wpc);
         check($sformatf("vec%0d_winst", i), winst_o, vecs[i].exp_winst);
         check($sformatf("vec%0d_mreq", i), {31'd0, mem_req_o}, {31'd0, vecs[i].exp_mreq});
         check($sformatf("vec%0d_maddr", i), mem_addr_o, vecs[i].exp_maddr);
         check($sformatf("vec%0d_rpc", i), rpc_o, vecs[i].pc);
      end

      $display("[TB] grant gaps");
      run_miss("gnt_gap", 32'h3000, ~32'h0000_000C, 32'hFFFF_FFFF, FILL_LAT + 2, 32'h14131211);

      $display("[TB] flush mid-refill");
      apply_stimulus(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("flush_valid", {31'd0, valid_o}, 32'd0);
      check("flush_we", {31'd0, we_o}, 32'd0);
      check("flush_mreq", {31'd0, mem_req_o}, 32'd0);
      run_miss("after_flush", 32'h2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FILL_LAT, 32'h12345678);

      $display("[TB] reset mid-refill");
      apply_stimulus(1'b1, 32'h5000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h5000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h5000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 32'h5000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_idle_outputs("rst_mid");
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
         if (valid_o || we_o || mem_req_o) pulses++;
      end
      check("rst_mid_quiet", 32'(pulses), 32'd0);
      run_miss("after_rst", 32'h1004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FILL_LAT, 32'h00A00513);

      $display("[TB] rdy stall");
      run_miss("rdy_stall", 32'h1004, 32'hFFFF_FFFF, ~32'h0000_0038, FILL_LAT + 3, 32'h00A00513);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
